axil_cmd_master: RTL and testbench

- Synthesizable AXI4-Lite initiator. Converts single-word command requests (write, read, poll-until-bit-set) into AXI4-Lite transactions on an M_AXI port, then returns one response per command.
- Replaces bench-driven bus sequencing. Lets on-chip control logic drive the adder_amba register slave (r0/r1/r2, ctrl/status, LED register) directly.

---
 rtl/axil_pkg.sv | 37 +++
 rtl/axil_cmd_master.sv | 234 +++++++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite command master: opcodes, FSM state codes,
// response codes and the adder_amba register map.
package axil_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_POLL  = 2'b10
  } op_e;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_AW_W = 3'd1;
  localparam logic [2:0] WR_B    = 3'd2;
  localparam logic [2:0] RD_AR   = 3'd3;
  localparam logic [2:0] RD_R    = 3'd4;
  localparam logic [2:0] RSP     = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] ADDR_R0          = 32'h0000_0000;
  localparam logic [31:0] ADDR_R1          = 32'h0000_0004;
  localparam logic [31:0] ADDR_R2          = 32'h0000_0008;
  localparam logic [31:0] ADDR_CTRL_STATUS = 32'h0000_000C;
  localparam logic [31:0] ADDR_LED         = 32'h0000_0010;

  // The reserved encoding 2'b11 behaves as a plain read.
  function automatic op_e decode_op(input logic [1:0] raw);
    case (raw)
      2'b00:   return OP_WRITE;
      2'b10:   return OP_POLL;
      default: return OP_READ;
    endcase
  endfunction

endpackage

// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator: turns single-word WRITE / READ / POLL commands into bus
// transactions, one outstanding at a time, and returns one response per command.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_POLLS  = 256
) (
  input  logic                             M_AXI_ACLK,
  input  logic                             M_AXI_ARESET,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [1:0]                       cmd_op,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]          cmd_wstrb,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [1:0]                       rsp_resp,
  output logic                             rsp_timeout,
  output logic [$clog2(MAX_POLLS+1)-1:0]   rsp_count,
  output logic [ADDR_WIDTH-1:0]            M_AXI_AWADDR,
  output logic [2:0]                       M_AXI_AWPROT,
  output logic                             M_AXI_AWVALID,
  input  logic                             M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]            M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]          M_AXI_WSTRB,
  output logic                             M_AXI_WVALID,
  input  logic                             M_AXI_WREADY,
  input  logic [1:0]                       M_AXI_BRESP,
  input  logic                             M_AXI_BVALID,
  output logic                             M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]            M_AXI_ARADDR,
  output logic [2:0]                       M_AXI_ARPROT,
  output logic                             M_AXI_ARVALID,
  input  logic                             M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]            M_AXI_RDATA,
  input  logic [1:0]                       M_AXI_RRESP,
  input  logic                             M_AXI_RVALID,
  output logic                             M_AXI_RREADY
);

  localparam int              CNT_W   = $clog2(MAX_POLLS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_POLLS);

  logic [2:0]              state_q,       state_d;
  op_e                     op_q,          op_d;
  logic [ADDR_WIDTH-1:0]   addr_q,        addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q,       wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q,       wstrb_d;
  logic                    cmd_ready_q,   cmd_ready_d;
  logic                    awvalid_q,     awvalid_d;
  logic                    wvalid_q,      wvalid_d;
  logic                    bready_q,      bready_d;
  logic                    arvalid_q,     arvalid_d;
  logic                    rready_q,      rready_d;
  logic                    rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q,   rsp_rdata_d;
  logic [1:0]              rsp_resp_q,    rsp_resp_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]        poll_cnt_q,    poll_cnt_d;
  logic [CNT_W-1:0]        poll_next;
  logic                    aw_done, w_done;
  op_e                     new_op;

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch can leave one unassigned and infer a latch.
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    cmd_ready_d   = cmd_ready_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    poll_cnt_d    = poll_cnt_q;
    aw_done       = 1'b0;
    w_done        = 1'b0;
    new_op        = decode_op(cmd_op);
    poll_next     = (poll_cnt_q == MAX_CNT) ? poll_cnt_q : poll_cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d   = 1'b0;
          op_d          = new_op;
          addr_d        = cmd_addr;
          wdata_d       = cmd_wdata;
          wstrb_d       = cmd_wstrb;
          poll_cnt_d    = '0;
          rsp_rdata_d   = '0;
          rsp_resp_d    = RESP_OKAY;
          rsp_timeout_d = 1'b0;
          if (new_op == OP_WRITE) begin
            state_d   = WR_AW_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end

      WR_AW_W: begin
        // A dropped VALID doubles as that channel's done flag.
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        aw_done = !awvalid_d;
        w_done  = !wvalid_d;
        if (aw_done && w_done) begin
          state_d  = WR_B;
          bready_d = 1'b1;
        end
      end

      WR_B: begin
        if (M_AXI_BVALID && bready_q) begin
          bready_d    = 1'b0;
          rsp_resp_d  = M_AXI_BRESP;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end

      RD_AR: begin
        if (arvalid_q && M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end

      RD_R: begin
        if (M_AXI_RVALID && rready_q) begin
          rready_d    = 1'b0;
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
          poll_cnt_d  = poll_next;
          // A match or a bus error ends a poll before the timeout is considered.
          if (op_q != OP_POLL || (M_AXI_RDATA & wdata_q) != '0 || M_AXI_RRESP != RESP_OKAY) begin
            rsp_valid_d = 1'b1;
            state_d     = RSP;
          end else if (poll_next == MAX_CNT) begin
            rsp_timeout_d = 1'b1;
            rsp_valid_d   = 1'b1;
            state_d       = RSP;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_AR;
          end
        end
      end

      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q       <= IDLE;
      op_q          <= OP_WRITE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      cmd_ready_q   <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= RESP_OKAY;
      rsp_timeout_q <= 1'b0;
      poll_cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking here so every flop samples pre-edge values regardless of statement order.
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      cmd_ready_q   <= cmd_ready_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      poll_cnt_q    <= poll_cnt_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign rsp_count     = poll_cnt_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master against a small adder_amba-like slave model
// with programmable ready/valid stalls and error injection.
module tb_axil_cmd_master;
  import axil_pkg::*;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic [2:0]  rsp_count;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  axil_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_POLLS(4)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .rsp_count(rsp_count),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  int          aw_delay = 0, w_delay = 0, r_delay = 0, err_at = 0;
  logic        b_block = 1'b0;
  int          aw_wait, w_wait, r_wait, status_reads, ar_hs_cnt, b_cnt, rd_total;
  logic        aw_got, w_got, r_pend;
  logic [31:0] aw_addr_l, w_data_l, reg_r0, reg_r1, reg_r2, reg_ctrl, reg_led;
  logic [3:0]  w_strb_l;
  logic        aw_now, w_now;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;

  assign awready = (aw_wait >= aw_delay);
  assign wready  = (w_wait >= w_delay);
  assign arready = 1'b1;
  assign aw_now  = aw_got || (awvalid && awready);
  assign w_now   = w_got || (wvalid && wready);
  assign wr_addr = aw_got ? aw_addr_l : awaddr;
  assign wr_data = w_got ? w_data_l : wdata;
  assign wr_strb = w_got ? w_strb_l : wstrb;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] s);
    logic [31:0] v;
    v = old_v;
    for (int i = 0; i < 4; i++) if (s[i]) v[8*i +: 8] = new_v[8*i +: 8];
    return v;
  endfunction

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    case (a)
      ADDR_R0:          return reg_r0;
      ADDR_R1:          return reg_r1;
      ADDR_R2:          return reg_r2;
      ADDR_CTRL_STATUS: return {status_reads >= 2, 30'd0, reg_ctrl[0]};
      ADDR_LED:         return reg_led;
      default:          return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_wait <= 0; w_wait <= 0; r_wait <= 0; status_reads <= 0;
      ar_hs_cnt <= 0; b_cnt <= 0; rd_total <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0;
      reg_r0 <= '0; reg_r1 <= '0; reg_r2 <= '0; reg_ctrl <= '0; reg_led <= '0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
    end else begin
      if (awvalid && !awready) aw_wait <= aw_wait + 1;
      if (awvalid && awready) begin aw_wait <= 0; aw_addr_l <= awaddr; aw_got <= 1'b1; end
      if (wvalid && !wready) w_wait <= w_wait + 1;
      if (wvalid && wready) begin w_wait <= 0; w_data_l <= wdata; w_strb_l <= wstrb; w_got <= 1'b1; end
      if (aw_now && w_now && !bvalid && !b_block) begin
        case (wr_addr)
          ADDR_R0:  reg_r0  <= merge(reg_r0, wr_data, wr_strb);
          ADDR_R1:  reg_r1  <= merge(reg_r1, wr_data, wr_strb);
          ADDR_LED: reg_led <= merge(reg_led, wr_data, wr_strb);
          ADDR_CTRL_STATUS: begin
            reg_ctrl     <= wr_data;
            reg_r2       <= wr_data[0] ? reg_r0 - reg_r1 : reg_r0 + reg_r1;
            status_reads <= 0;
          end
          default: ;
        endcase
        bvalid <= 1'b1; bresp <= RESP_OKAY; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= b_cnt + 1;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        ar_hs_cnt <= ar_hs_cnt + 1;
        rd_total  <= rd_total + 1;
        if (araddr == ADDR_CTRL_STATUS) status_reads <= status_reads + 1;
        if (rd_total + 1 == err_at) begin rdata <= '0; rresp <= RESP_SLVERR; end
        else begin rdata <= slave_rd(araddr); rresp <= RESP_OKAY; end
        if (r_delay == 0) rvalid <= 1'b1;
        else begin r_pend <= 1'b1; r_wait <= r_delay - 1; end
      end else if (r_pend) begin
        if (r_wait == 0) begin rvalid <= 1'b1; r_pend <= 1'b0; end
        else r_wait <= r_wait - 1;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- checking helpers ----------------
  int          r_lat;
  logic        r_seen, r_tmo;
  logic [31:0] r_rdata;
  logic [1:0]  r_resp;
  logic [2:0]  r_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    check("cmd_ready_seen", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    r_lat = n; r_seen = rsp_valid; r_rdata = rsp_rdata; r_resp = rsp_resp;
    r_tmo = rsp_timeout; r_count = rsp_count;
    check("rsp_valid_seen", 32'(r_seen), 32'd1);
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    send_cmd(op, a, d, s);
    wait_rsp();
    ack_rsp();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int ar0, b0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_valids", 32'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 32'd0);
    check("rst_rsp_count", 32'(rsp_count), 32'd0);
    check("rst_prot", 32'({awprot, arprot}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Basic write / read-back with a zero-wait slave
    do_cmd(OP_WRITE, ADDR_R0, 32'h0000_0002, 4'hF);
    check("t1_wr_lat", 32'(r_lat), 32'd2);
    check("t1_wr_resp", 32'(r_resp), 32'd0);
    check("t1_wr_rdata", r_rdata, 32'd0);
    check("t1_wr_count", 32'(r_count), 32'd0);
    do_cmd(OP_READ, ADDR_R0, 32'h0, 4'h0);
    check("t1_rd_lat", 32'(r_lat), 32'd2);
    check("t1_rd_rdata", r_rdata, 32'h0000_0002);
    check("t1_rd_count", 32'(r_count), 32'd1);
    check("t1_rd_resp", 32'(r_resp), 32'd0);
    do_cmd(2'b11, ADDR_R0, 32'h0, 4'h0);
    check("rsvd_rdata", r_rdata, 32'h0000_0002);
    check("rsvd_count", 32'(r_count), 32'd1);
    do_cmd(OP_WRITE, ADDR_LED, 32'hAABB_CCDD, 4'b0101);
    do_cmd(OP_READ, ADDR_LED, 32'h0, 4'h0);
    check("strb_rdata", r_rdata, 32'h00BB_00DD);

    // Subtract, then poll status done bit (set on the third status read)
    do_cmd(OP_WRITE, ADDR_R0, 32'd2, 4'hF);
    do_cmd(OP_WRITE, ADDR_R1, 32'd1, 4'hF);
    do_cmd(OP_WRITE, ADDR_CTRL_STATUS, 32'h1, 4'hF);
    do_cmd(OP_POLL, ADDR_CTRL_STATUS, 32'h8000_0000, 4'h0);
    check("t2_poll_rdata", r_rdata, 32'h8000_0001);
    check("t2_poll_tmo", 32'(r_tmo), 32'd0);
    check("t2_poll_count", 32'(r_count), 32'd3);
    check("t2_poll_lat", 32'(r_lat), 32'd6);
    do_cmd(OP_READ, ADDR_R2, 32'h0, 4'h0);
    check("t2_r2", r_rdata, 32'h0000_0001);

    // SLVERR on the second read of a poll
    err_at = rd_total + 2;
    do_cmd(OP_POLL, ADDR_LED, 32'h0000_0002, 4'h0);
    check("t4_resp", 32'(r_resp), 32'(RESP_SLVERR));
    check("t4_count", 32'(r_count), 32'd2);
    check("t4_tmo", 32'(r_tmo), 32'd0);
    check("t4_rdata", r_rdata, 32'd0);
    err_at = 0;

    // Mask 0 never matches: MAX_POLLS reads then timeout
    ar0 = ar_hs_cnt;
    do_cmd(OP_POLL, ADDR_CTRL_STATUS, 32'h0, 4'h0);
    check("t5_ar_hs", 32'(ar_hs_cnt - ar0), 32'd4);
    check("t5_tmo", 32'(r_tmo), 32'd1);
    check("t5_count", 32'(r_count), 32'd4);
    check("t5_lat", 32'(r_lat), 32'd8);
    check("t5_rdata", r_rdata, 32'h8000_0001);

    // Stalled write: AWREADY after 1 wait cycle, WREADY after 4
    aw_delay = 1; w_delay = 4; b0 = b_cnt;
    send_cmd(OP_WRITE, ADDR_LED, 32'h1234_5678, 4'hF);
    check("t3_c1_valids", 32'({awvalid, wvalid}), 32'b11);
    @(negedge clk);
    @(negedge clk);
    check("t3_c3_valids", 32'({awvalid, wvalid}), 32'b01);
    check("t3_c3_wdata", wdata, 32'h1234_5678);
    @(negedge clk);
    check("t3_c4_wdata", wdata, 32'h1234_5678);
    @(negedge clk);
    check("t3_c5_wvalid", 32'(wvalid), 32'd1);
    @(negedge clk);
    check("t3_c6_wvalid_bready", 32'({wvalid, bready}), 32'b01);
    wait_rsp();
    ack_rsp();
    check("t3_wr_resp", 32'(r_resp), 32'd0);
    repeat (3) @(negedge clk);
    check("t3_single_rsp", 32'(rsp_valid), 32'd0);
    check("t3_b_count", 32'(b_cnt - b0), 32'd1);
    aw_delay = 0; w_delay = 0; r_delay = 5;
    send_cmd(OP_READ, ADDR_LED, 32'h0, 4'h0);
    @(negedge clk);
    check("t3_rd_wait", 32'({arvalid, rready}), 32'b01);
    wait_rsp();
    ack_rsp();
    check("t3_rd_rdata", r_rdata, 32'h1234_5678);
    r_delay = 0;

    // Reset while waiting in WR_B
    b_block = 1'b1;
    send_cmd(OP_WRITE, ADDR_R0, 32'd5, 4'hF);
    @(negedge clk);
    check("t6a_in_wr_b", 32'(bready), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6a_valids", 32'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 32'd0);
    check("t6a_cmd_ready", 32'(cmd_ready), 32'd0);
    b_block = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("t6a_ready_after", 32'(cmd_ready), 32'd1);
    do_cmd(OP_WRITE, ADDR_R0, 32'd5, 4'hF);
    check("t6a_wr_lat", 32'(r_lat), 32'd2);
    do_cmd(OP_READ, ADDR_R0, 32'h0, 4'h0);
    check("t6a_rd", r_rdata, 32'd5);

    // Reset while a response is held with rsp_ready low
    send_cmd(OP_READ, ADDR_R0, 32'h0, 4'h0);
    wait_rsp();
    repeat (2) @(negedge clk);
    check("t6b_held_valid", 32'(rsp_valid), 32'd1);
    check("t6b_held_rdata", rsp_rdata, 32'd5);
    #2 rst = 1'b1;
    #1;
    check("t6b_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6b_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("t6b_ready_after", 32'(cmd_ready), 32'd1);
    do_cmd(OP_WRITE, ADDR_R1, 32'd7, 4'hF);
    check("t6b_wr_resp", 32'(r_resp), 32'd0);
    do_cmd(OP_READ, ADDR_R1, 32'h0, 4'h0);
    check("t6b_rd", r_rdata, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
